// File: rtl/boot_loader.sv
// boot_loader: takes a length byte then payload bytes over valid/ready, writes them to program RAM from address 0, then raises cpu_run.
// Optional BOOT_LOADER_CHECKSUM_EN: a trailing XOR checksum byte gates cpu_run; a mismatch parks the loader in a sticky err state.
module boot_loader #(
    parameter int AW = 7,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          mem_req,
    output logic          mem_rnw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    input  logic          mem_ack,
    output logic          cpu_run,
    output logic          busy,
    output logic          err,
    output logic [AW:0]   count
);
    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];
    localparam logic [DW:0] DEPTH_W = DEPTH[DW:0];

`ifdef BOOT_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, CHK, ERR} state_e;
`else
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_e;
`endif

    state_e        state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [DW-1:0] csum_q, csum_d;
`endif

    logic          xfer;
    logic [AW:0]   cnt_inc;
    logic [DW:0]   len_raw;

    assign xfer    = in_valid & in_ready;
    assign cnt_inc = cnt_q + {{AW{1'b0}}, 1'b1};
    assign len_raw = {1'b0, in_data};

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    // Zero means a full RAM image; anything larger than the RAM is clamped.
                    len_d   = (in_data == '0 || len_raw > DEPTH_W) ? DEPTH_L : len_raw[AW:0];
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (xfer) begin
                    data_d  = in_data;
                    addr_d  = cnt_q[AW-1:0];
`ifdef BOOT_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ in_data;
`endif
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = DONE;
`endif
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            CHK: begin
                if (xfer) begin
                    state_d = (in_data == csum_q) ? DONE : ERR;
                end
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        mem_req  = 1'b0;
        cpu_run  = 1'b0;
        busy     = 1'b0;
        err      = 1'b0;
        case (state_q)
            IDLE:  in_ready = 1'b1;
            LOAD:  begin in_ready = 1'b1; busy = 1'b1; end
            WRITE: begin mem_req  = 1'b1; busy = 1'b1; end
            DONE:  cpu_run = 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
            CHK:   begin in_ready = 1'b1; busy = 1'b1; end
            ERR:   err = 1'b1;
`endif
            default: ;
        endcase
    end

    assign mem_rnw  = 1'b0;
    assign mem_addr = addr_q;
    assign mem_data = data_q;
    assign count    = cnt_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: table of load vectors plus hand sequences for stray ack, reset mid-write and checksum.
module tb_boot_loader;
    localparam int AW = 7;
    localparam int DW = 8;

    logic          CLK      = 1'b0;
    logic          RSTn     = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          in_ready;
    logic          mem_req;
    logic          mem_rnw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_ack;
    logic          cpu_run;
    logic          busy;
    logic          err;
    logic [AW:0]   count;

    logic resp_ack  = 1'b0;
    logic stray_ack = 1'b0;
    assign mem_ack = resp_ack | stray_ack;

    int checks    = 0;
    int failures  = 0;
    int ack_delay = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        logic [7:0] len;
        int         pat;
        int         dly;
        bit         bp;
        int         exp_cnt;
    } vec_t;

    boot_loader #(.AW(AW), .DW(DW)) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_req  (mem_req),
        .mem_rnw  (mem_rnw),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_ack  (mem_ack),
        .cpu_run  (cpu_run),
        .busy     (busy),
        .err      (err),
        .count    (count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (RSTn) check("req_run_exclusive", 32'(mem_req & cpu_run), 0);
    end

    // Memory model: acks after ack_delay cycles, checks address/data stability and the scoreboard.
    initial begin : responder
        wr_t           exp_w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            dly;
        bit            aborted;
        forever begin
            @(posedge CLK); #1;
            if (RSTn && mem_req) begin
                a       = mem_addr;
                d       = mem_data;
                dly     = ack_delay;
                aborted = 1'b0;
                for (int k = 0; k < dly; k++) begin
                    @(posedge CLK); #1;
                    if (!mem_req) begin
                        aborted = 1'b1;
                        break;
                    end
                    check("addr_stable", 32'(mem_addr), 32'(a));
                    check("data_stable", 32'(mem_data), 32'(d));
                    check("in_ready_in_write", 32'(in_ready), 0);
                end
                if (!aborted) begin
                    check("mem_rnw", 32'(mem_rnw), 0);
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_write addr=%0h data=%0h required=no_write", a, d);
                    end else begin
                        exp_w = sb.pop_front();
                        check("write_addr", 32'(a), 32'(exp_w.a));
                        check("write_data", 32'(d), 32'(exp_w.d));
                    end
                    resp_ack = 1'b1;
                    @(posedge CLK); #1;
                    resp_ack = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic reset_dut();
        in_valid  = 1'b0;
        stray_ack = 1'b0;
        RSTn      = 1'b0;
        sb.delete();
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bp, output bit ok);
        int guard;
        if (bp) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        while (!in_ready && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        ok = in_ready;
        if (ok) @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic send_payload(input logic [7:0] b, input int idx);
        bit ok;
        sb.push_back(wr_t'{a: AW'(idx), d: b});
        send_byte(b, 1'b0, ok);
        check("payload_accept", 32'(ok), 1);
    endtask

    task automatic wait_done(output bit ok);
        int guard = 0;
        while (!(cpu_run || err) && guard < 3000) begin
            @(negedge CLK);
            guard++;
        end
        ok = cpu_run || err;
    endtask

    initial begin : main
        vec_t       vecs[5];
        bit         ok;
        logic [7:0] b;
        logic [7:0] cs;

        vecs[0] = '{8'h03, 0, 1, 1'b0, 3};
        vecs[1] = '{8'h00, 1, 0, 1'b0, 128};
        vecs[2] = '{8'hC8, 1, 0, 1'b0, 128};
        vecs[3] = '{8'h05, 2, 5, 1'b1, 5};
        vecs[4] = '{8'h01, 2, 2, 1'b1, 1};

        #2 RSTn = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_mem_req",  32'(mem_req),  0);
        check("rst_mem_rnw",  32'(mem_rnw),  0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_data", 32'(mem_data), 0);
        check("rst_cpu_run",  32'(cpu_run),  0);
        check("rst_busy",     32'(busy),     0);
        check("rst_err",      32'(err),      0);
        check("rst_count",    32'(count),    0);
        @(negedge CLK);
        RSTn = 1'b1;

        for (int v = 0; v < 5; v++) begin
            reset_dut();
            ack_delay = vecs[v].dly;
            send_byte(vecs[v].len, vecs[v].bp, ok);
            check("len_accept", 32'(ok), 1);
            check("busy_after_len", 32'(busy), 1);
            cs = 8'h00;
            for (int i = 0; i < vecs[v].exp_cnt; i++) begin
                case (vecs[v].pat)
                    0:       b = 8'(17 * (i + 1));
                    1:       b = 8'(i);
                    default: b = 8'($urandom);
                endcase
                sb.push_back(wr_t'{a: AW'(i), d: b});
                send_byte(b, vecs[v].bp, ok);
                check("byte_accept", 32'(ok), 1);
                check("req_after_accept", 32'(mem_req), 1);
                check("addr_after_accept", 32'(mem_addr), 32'(i));
                cs = cs ^ b;
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            send_byte(cs, vecs[v].bp, ok);
            check("csum_accept", 32'(ok), 1);
`endif
            wait_done(ok);
            check("done_reached", 32'(ok), 1);
            check("final_count",    32'(count),    32'(vecs[v].exp_cnt));
            check("final_cpu_run",  32'(cpu_run),  1);
            check("final_in_ready", 32'(in_ready), 0);
            check("final_mem_req",  32'(mem_req),  0);
            check("final_busy",     32'(busy),     0);
            check("final_err",      32'(err),      0);
            check("sb_drained",     32'(sb.size()), 0);
            in_valid = 1'b1;
            in_data  = 8'h5A;
            repeat (4) begin
                @(negedge CLK);
                check("in_ready_after_done", 32'(in_ready), 0);
            end
            in_valid = 1'b0;
            check("count_after_extra", 32'(count), 32'(vecs[v].exp_cnt));
        end

        // Stray acknowledge while no request is outstanding.
        reset_dut();
        ack_delay = 0;
        send_byte(8'h02, 1'b0, ok);
        stray_ack = 1'b1;
        repeat (3) @(negedge CLK);
        check("stray_ack_count", 32'(count), 0);
        check("stray_ack_req",   32'(mem_req), 0);
        stray_ack = 1'b0;
        send_payload(8'hC3, 0);
        send_payload(8'h3C, 1);
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_byte(8'hFF, 1'b0, ok);
`endif
        wait_done(ok);
        check("stray_done_count", 32'(count), 2);
        check("stray_done_run",   32'(cpu_run), 1);

        // Reset while the second write is still waiting for its acknowledge.
        reset_dut();
        ack_delay = 3;
        send_byte(8'h03, 1'b0, ok);
        send_payload(8'h55, 0);
        ack_delay = 20;
        send_payload(8'h66, 1);
        check("pre_reset_req",   32'(mem_req),  1);
        check("pre_reset_addr",  32'(mem_addr), 1);
        check("pre_reset_count", 32'(count),    1);
        #2 RSTn = 1'b0;
        #1;
        check("async_rst_req",      32'(mem_req),  0);
        check("async_rst_count",    32'(count),    0);
        check("async_rst_in_ready", 32'(in_ready), 1);
        check("async_rst_busy",     32'(busy),     0);
        check("async_rst_addr",     32'(mem_addr), 0);
        sb.delete();
        @(negedge CLK);
        RSTn = 1'b1;
        ack_delay = 0;
        send_byte(8'h01, 1'b0, ok);
        send_payload(8'hAA, 0);
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_byte(8'hAA, 1'b0, ok);
`endif
        wait_done(ok);
        check("reload_count", 32'(count), 1);
        check("reload_run",   32'(cpu_run), 1);
        check("reload_sb",    32'(sb.size()), 0);

`ifdef BOOT_LOADER_CHECKSUM_EN
        reset_dut();
        send_byte(8'h02, 1'b0, ok);
        send_payload(8'h0F, 0);
        send_payload(8'hF0, 1);
        send_byte(8'hFF, 1'b0, ok);
        wait_done(ok);
        check("csum_good_run", 32'(cpu_run), 1);
        check("csum_good_err", 32'(err), 0);

        reset_dut();
        send_byte(8'h02, 1'b0, ok);
        send_payload(8'h0F, 0);
        send_payload(8'hF0, 1);
        send_byte(8'h00, 1'b0, ok);
        wait_done(ok);
        check("csum_bad_err",      32'(err), 1);
        check("csum_bad_run",      32'(cpu_run), 0);
        check("csum_bad_in_ready", 32'(in_ready), 0);
        check("csum_bad_busy",     32'(busy), 0);
        check("csum_bad_count",    32'(count), 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
